temporizador_descendente: RTL and testbench

TEMPORIZADOR_DESCENDENTE -- requirements
Module: temporizador_descendente

---
 rtl/temporizador_pkg.sv | 13 +
 rtl/temporizador_descendente.sv | 91 +++++++++
 tb/tb_temporizador_descendente.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/temporizador_pkg.sv
// Shared types and constants for the down-counting timer.
// Holds the controller state encoding and the default count width.
package temporizador_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/temporizador_descendente.sv
// Loadable down-counting timer with optional auto-reload.
// Ports: clk, rst (sync, active-high), EN (count tick), load + D (start
// value), auto_reload; outputs Q (remaining count), busy, done (pulse).
module temporizador_descendente
    import temporizador_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         EN,
    input  logic         load,
    input  logic [N-1:0] D,
    input  logic         auto_reload,
    output logic [N-1:0] Q,
    output logic         busy,
    output logic         done
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] rld_q, rld_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rld_d   = rld_q;
        done_d  = 1'b0;

        if (load) begin
            q_d   = D;
            rld_d = D;
            if (D == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    if (EN) begin
                        if (q_q > ONE) begin
                            q_d = q_q - ONE;
                        end else if (auto_reload) begin
                            // Restart in place: stay in RUN, pulse done.
                            q_d    = rld_q;
                            done_d = 1'b1;
                        end else begin
                            q_d     = '0;
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered from the next state so they never see a
        // combinational path from the inputs.
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            rld_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rld_q   <= rld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_temporizador_descendente.sv
// Self-checking bench for temporizador_descendente (N=8).
// Directed scenarios with literal expectations plus a randomized phase.
module tb_temporizador_descendente;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         EN = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] D = '0;
    logic         auto_reload = 1'b0;
    logic [N-1:0] Q;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: a count, a stored start value and a "timing" flag.
    int m_q    = 0;
    int m_rld  = 0;
    bit m_run  = 1'b0;
    bit m_done = 1'b0;

    temporizador_descendente #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .EN          (EN),
        .load        (load),
        .D           (D),
        .auto_reload (auto_reload),
        .Q           (Q),
        .busy        (busy),
        .done        (done)
    );

    always #50 clk = ~clk;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_q   = 0;
            m_rld = 0;
            m_run = 1'b0;
        end else if (load) begin
            m_q   = int'(D);
            m_rld = int'(D);
            m_run = (D != 0);
            m_done = (D == 0);
        end else if (m_run && EN) begin
            if (m_q >= 2) begin
                m_q = m_q - 1;
            end else if (auto_reload) begin
                m_q    = m_rld;
                m_done = 1'b1;
            end else begin
                m_q    = 0;
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (int'(Q) == m_q && busy == m_run && done == m_done)
                n_pass++;
            else
                $display("FAIL model t=%0t Q=%0d busy=%0b done=%0b want Q=%0d busy=%0b done=%0b",
                         $time, Q, busy, done, m_q, m_run, m_done);
        end
    end

    task automatic lit(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", name, got, exp);
    endtask

    task automatic step(input bit r, input bit ld, input int d,
                        input bit en, input bit ar);
        rst         = r;
        load        = ld;
        D           = d[N-1:0];
        EN          = en;
        auto_reload = ar;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_ar [9];
        int cnt;
        bit seen;

        exp_ar = '{2, 1, 3, 2, 1, 3, 2, 1, 3};

        // Reset while a load is requested.
        step(1, 1, 9, 0, 0);
        chk_en = 1'b1;
        lit("rst1_q", Q, 0);
        lit("rst1_busy", busy, 0);
        lit("rst1_done", done, 0);
        step(1, 1, 9, 1, 0);
        lit("rst2_q", Q, 0);
        lit("rst2_busy", busy, 0);
        step(0, 0, 0, 1, 0);
        lit("idle_q", Q, 0);
        lit("idle_busy", busy, 0);

        // Single shot from 5.
        step(0, 1, 5, 0, 0);
        lit("ss_load_q", Q, 5);
        lit("ss_load_busy", busy, 1);
        for (int i = 4; i >= 0; i--) begin
            step(0, 0, 0, 1, 0);
            lit("ss_q", Q, i);
            lit("ss_done", done, (i == 0) ? 1 : 0);
            lit("ss_busy", busy, (i == 0) ? 0 : 1);
        end
        step(0, 0, 0, 1, 0);
        lit("ss_after_done", done, 0);
        lit("ss_after_q", Q, 0);

        // Pause with EN low.
        step(0, 1, 3, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            lit("pause_q", Q, 2);
            lit("pause_busy", busy, 1);
        end
        step(0, 0, 0, 1, 0);
        lit("resume_done0", done, 0);
        step(0, 0, 0, 1, 0);
        lit("resume_done1", done, 1);

        // Auto-reload period 3.
        step(0, 1, 3, 0, 1);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 1, 1);
            lit("ar_q", Q, exp_ar[i]);
            lit("ar_done", done, (exp_ar[i] == 3) ? 1 : 0);
            lit("ar_busy", busy, 1);
        end

        // Preemption mid-count and on the terminal tick.
        step(0, 1, 6, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        lit("pre_q4", Q, 4);
        step(0, 1, 10, 1, 0);
        lit("pre_q10", Q, 10);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0);
        lit("pre_q1", Q, 1);
        step(0, 1, 7, 1, 0);
        lit("pre_term_q", Q, 7);
        lit("pre_term_done", done, 0);
        lit("pre_term_busy", busy, 1);

        // Reset mid-count at Q=7.
        step(1, 0, 0, 1, 0);
        lit("rstmid_q", Q, 0);
        lit("rstmid_done", done, 0);
        lit("rstmid_busy", busy, 0);

        // Load of zero.
        step(0, 1, 0, 1, 0);
        lit("ld0_done", done, 1);
        lit("ld0_busy", busy, 0);
        step(0, 0, 0, 1, 0);
        lit("ld0_after", done, 0);

        // Full range: 255 EN ticks to done.
        step(0, 1, 255, 0, 0);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 300) begin
            step(0, 0, 0, 1, 0);
            cnt++;
            seen = done;
        end
        lit("full_ticks", cnt, 255);
        step(0, 0, 0, 1, 0);
        lit("full_nowrap", Q, 0);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                            : $urandom_range(0, 6);
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 8),
                 d,
                 ($urandom_range(0, 99) < 65),
                 $urandom_range(0, 1));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
